// File: rtl/cpu_types_pkg.sv
// Shared CPU types: opcodes, ALU ops, register widths and the ID/EX bundle.
package cpu_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        J     = 6'h02,
        JAL   = 6'h03,
        BEQ   = 6'h04,
        BNE   = 6'h05,
        ADDI  = 6'h08,
        ADDIU = 6'h09,
        SLTI  = 6'h0a,
        SLTIU = 6'h0b,
        ANDI  = 6'h0c,
        ORI   = 6'h0d,
        XORI  = 6'h0e,
        LUI   = 6'h0f,
        LW    = 6'h23,
        LBU   = 6'h24,
        LHU   = 6'h25,
        SB    = 6'h28,
        SH    = 6'h29,
        SW    = 6'h2b,
        LL    = 6'h30,
        SC    = 6'h38,
        HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef struct packed {
        opcode_t    opcode;
        regbits_t   rs;
        regbits_t   rt;
        regbits_t   rd;
        logic [1:0] reg_dest;
        aluop_t     aluop;
        logic       wen;
        logic       memren;
        logic       memwen;
        logic [15:0] imm;
        word_t      rdat1;
        word_t      rdat2;
        word_t      pc4;
    } id_ex_t;

    // Opcode 0 with every field zero is a harmless sll $0,$0,0.
    localparam id_ex_t ID_EX_NOP = '0;

endpackage

// File: rtl/data_path_muxs_pkg.sv
// Datapath mux select encodings shared across stages.
package data_path_muxs_pkg;

    localparam logic [1:0] SEL_RD  = 2'd0;
    localparam logic [1:0] SEL_RT  = 2'd1;
    localparam logic [1:0] SEL_R31 = 2'd2;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector between the load in EX and the instruction in ID.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  opcode_t  opcode_ID,
    input  regbits_t rs_ID,
    input  regbits_t rt_ID,
    input  logic     memren_EX,
    input  logic     WEN_EX,
    input  regbits_t rt_EX,
    output logic     lu_haz
);

    logic reads_rt;

    always_comb begin
        reads_rt = 1'b0;
        unique case (opcode_ID)
            RTYPE, BEQ, BNE, SW, SC: reads_rt = 1'b1;
            default:                 reads_rt = 1'b0;
        endcase
    end

    assign lu_haz = memren_EX & WEN_EX & (rt_EX != '0)
                  & ((rt_EX == rs_ID) | (reads_rt & (rt_EX == rt_ID)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, MEM freeze and flush.
module id_ex_stage
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mem_wait,
    input  logic             flush,
    input  opcode_t          opcode_ID,
    input  regbits_t         rs_ID,
    input  regbits_t         rt_ID,
    input  regbits_t         rd_ID,
    input  logic [1:0]       reg_dest_ID,
    input  aluop_t           aluop_ID,
    input  logic             WEN_ID,
    input  logic             memren_ID,
    input  logic             memwen_ID,
    input  logic [15:0]      imm_ID,
    input  logic [31:0]      rdat1_ID,
    input  logic [31:0]      rdat2_ID,
    input  logic [31:0]      pc4_ID,
    output opcode_t          opcode_EX,
    output regbits_t         rs_EX,
    output regbits_t         rt_EX,
    output regbits_t         rd_EX,
    output logic [1:0]       reg_dest_EX,
    output aluop_t           aluop_EX,
    output logic             WEN_EX,
    output logic             memren_EX,
    output logic             memwen_EX,
    output logic [15:0]      imm_EX,
    output logic [31:0]      rdat1_EX,
    output logic [31:0]      rdat2_EX,
    output logic [31:0]      pc4_EX,
    output logic             stall_ID,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic {RUN, BUBBLE} state_t;

    state_t state, state_n;
    logic   flush_pend, flush_pend_n;
    logic   lu_haz;
    logic   bump_bubble;
    id_ex_t ex_q, ex_n, id_bus;

    assign id_bus = '{
        opcode:   opcode_ID,
        rs:       rs_ID,
        rt:       rt_ID,
        rd:       rd_ID,
        reg_dest: reg_dest_ID,
        aluop:    aluop_ID,
        wen:      WEN_ID,
        memren:   memren_ID,
        memwen:   memwen_ID,
        imm:      imm_ID,
        rdat1:    rdat1_ID,
        rdat2:    rdat2_ID,
        pc4:      pc4_ID
    };

    hazard_detect u_haz (
        .opcode_ID (opcode_ID),
        .rs_ID     (rs_ID),
        .rt_ID     (rt_ID),
        .memren_EX (ex_q.memren),
        .WEN_EX    (ex_q.wen),
        .rt_EX     (ex_q.rt),
        .lu_haz    (lu_haz)
    );

    always_comb begin
        state_n      = state;
        flush_pend_n = flush_pend;
        ex_n         = ex_q;
        bump_bubble  = 1'b0;
        if (mem_wait) begin
            if (flush) flush_pend_n = 1'b1;
        end else if (flush | flush_pend) begin
            ex_n         = ID_EX_NOP;
            flush_pend_n = 1'b0;
            state_n      = RUN;
        end else if (state == RUN && lu_haz) begin
            ex_n        = ID_EX_NOP;
            state_n     = BUBBLE;
            bump_bubble = 1'b1;
        end else begin
            ex_n    = id_bus;
            state_n = RUN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            flush_pend <= 1'b0;
            ex_q       <= ID_EX_NOP;
            bubble_cnt <= '0;
            freeze_cnt <= '0;
        end else begin
            state      <= state_n;
            flush_pend <= flush_pend_n;
            ex_q       <= ex_n;
            if (bump_bubble && bubble_cnt != '1)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            if (mem_wait && freeze_cnt != '1)
                freeze_cnt <= freeze_cnt + CNT_W'(1);
        end
    end

    // A flush squashes the ID instruction, so it must not also stall it.
    assign stall_ID = ~RST & (mem_wait
                    | (state == RUN & lu_haz & ~flush & ~flush_pend));

    assign opcode_EX   = ex_q.opcode;
    assign rs_EX       = ex_q.rs;
    assign rt_EX       = ex_q.rt;
    assign rd_EX       = ex_q.rd;
    assign reg_dest_EX = ex_q.reg_dest;
    assign aluop_EX    = ex_q.aluop;
    assign WEN_EX      = ex_q.wen;
    assign memren_EX   = ex_q.memren;
    assign memwen_EX   = ex_q.memwen;
    assign imm_EX      = ex_q.imm;
    assign rdat1_EX    = ex_q.rdat1;
    assign rdat2_EX    = ex_q.rdat2;
    assign pc4_EX      = ex_q.pc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: latency, load-use, freeze, flush, reset.
module tb_id_ex_stage;
    import cpu_types_pkg::*;
    import data_path_muxs_pkg::*;

    localparam int CW = 4;

    logic CLK = 1'b0;
    logic RST;
    logic mem_wait, flush;
    opcode_t opcode_ID, opcode_EX;
    regbits_t rs_ID, rt_ID, rd_ID, rs_EX, rt_EX, rd_EX;
    logic [1:0] reg_dest_ID, reg_dest_EX;
    aluop_t aluop_ID, aluop_EX;
    logic WEN_ID, memren_ID, memwen_ID;
    logic WEN_EX, memren_EX, memwen_EX;
    logic [15:0] imm_ID, imm_EX;
    logic [31:0] rdat1_ID, rdat2_ID, pc4_ID;
    logic [31:0] rdat1_EX, rdat2_EX, pc4_EX;
    logic stall_ID;
    logic [CW-1:0] bubble_cnt, freeze_cnt;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    id_ex_stage #(.CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .mem_wait(mem_wait), .flush(flush),
        .opcode_ID(opcode_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .rd_ID(rd_ID), .reg_dest_ID(reg_dest_ID),
        .aluop_ID(aluop_ID), .WEN_ID(WEN_ID),
        .memren_ID(memren_ID), .memwen_ID(memwen_ID),
        .imm_ID(imm_ID), .rdat1_ID(rdat1_ID),
        .rdat2_ID(rdat2_ID), .pc4_ID(pc4_ID),
        .opcode_EX(opcode_EX), .rs_EX(rs_EX), .rt_EX(rt_EX),
        .rd_EX(rd_EX), .reg_dest_EX(reg_dest_EX),
        .aluop_EX(aluop_EX), .WEN_EX(WEN_EX),
        .memren_EX(memren_EX), .memwen_EX(memwen_EX),
        .imm_EX(imm_EX), .rdat1_EX(rdat1_EX),
        .rdat2_EX(rdat2_EX), .pc4_EX(pc4_EX),
        .stall_ID(stall_ID), .bubble_cnt(bubble_cnt),
        .freeze_cnt(freeze_cnt)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(input opcode_t op, input regbits_t rs,
                       input regbits_t rt, input regbits_t rd,
                       input logic wen, input logic mr,
                       input logic mw);
        opcode_ID   = op;
        rs_ID       = rs;
        rt_ID       = rt;
        rd_ID       = rd;
        reg_dest_ID = (op == RTYPE) ? SEL_RD : SEL_RT;
        aluop_ID    = ALU_ADD;
        WEN_ID      = wen;
        memren_ID   = mr;
        memwen_ID   = mw;
        imm_ID      = 16'h0;
        rdat1_ID    = 32'h0;
        rdat2_ID    = 32'h0;
        pc4_ID      = 32'h0;
        #1;
    endtask

    initial begin
        RST = 1'b1;
        mem_wait = 1'b0;
        flush = 1'b0;
        drv(RTYPE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check("rst_op", opcode_EX, 32'h0);
        check("rst_wen", WEN_EX, 32'h0);
        check("rst_stall", stall_ID, 32'h0);
        check("rst_bcnt", bubble_cnt, 32'h0);
        check("rst_fcnt", freeze_cnt, 32'h0);
        tick();
        RST = 1'b0;

        // one-cycle latency
        drv(ADDI, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
        imm_ID   = 16'h1234;
        rdat1_ID = 32'hdead_beef;
        rdat2_ID = 32'h0bad_f00d;
        pc4_ID   = 32'h0000_0104;
        tick();
        check("lat_op", opcode_EX, ADDI);
        check("lat_rt", rt_EX, 32'd2);
        check("lat_imm", imm_EX, 32'h1234);
        check("lat_r1", rdat1_EX, 32'hdead_beef);
        check("lat_r2", rdat2_EX, 32'h0bad_f00d);
        check("lat_pc4", pc4_EX, 32'h104);
        check("lat_dest", reg_dest_EX, SEL_RT);

        // load-use via rs
        drv(LW, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw_mr", memren_EX, 32'h1);
        drv(RTYPE, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
        check("rs_stall", stall_ID, 32'h1);
        tick();
        check("bub_op", opcode_EX, 32'h0);
        check("bub_wen", WEN_EX, 32'h0);
        check("bub_rs", rs_EX, 32'h0);
        check("bub_state", dut.state, 32'h1);
        check("bub_cnt1", bubble_cnt, 32'd1);
        check("bub_nostall", stall_ID, 32'h0);
        tick();
        check("add_rs", rs_EX, 32'd5);
        check("add_rd", rd_EX, 32'd7);
        check("add_wen", WEN_EX, 32'h1);
        check("add_state", dut.state, 32'h0);

        // rt-only dependency
        drv(LW, 5'd1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drv(SW, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1);
        check("sw_stall", stall_ID, 32'h1);
        drv(ADDI, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        check("addi_nostall", stall_ID, 32'h0);
        drv(LW, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        check("lw0_rt", rt_EX, 32'h0);
        drv(RTYPE, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("rt0_nostall", stall_ID, 32'h0);

        // freeze during bubble
        drv(LW, 5'd1, 5'd9, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drv(RTYPE, 5'd9, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        tick();
        check("fz_bcnt", bubble_cnt, 32'd2);
        mem_wait = 1'b1;
        #1;
        check("fz_stall0", stall_ID, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_stall", stall_ID, 32'h1);
            check("fz_op", opcode_EX, 32'h0);
            check("fz_state", dut.state, 32'h1);
        end
        check("fz_cnt3", freeze_cnt, 32'd3);
        mem_wait = 1'b0;
        #1;
        check("fz_rel_stall", stall_ID, 32'h0);
        tick();
        check("fz_rel_rd", rd_EX, 32'd4);
        check("fz_rel_rs", rs_EX, 32'd9);

        // flush while frozen
        drv(ORI, 5'd2, 5'd11, 5'd0, 1'b1, 1'b0, 1'b0);
        mem_wait = 1'b1;
        flush = 1'b1;
        tick();
        check("fl_hold_rd", rd_EX, 32'd4);
        check("fl_pend", dut.flush_pend, 32'h1);
        check("fl_fcnt", freeze_cnt, 32'd4);
        mem_wait = 1'b0;
        flush = 1'b0;
        #1;
        tick();
        check("fl_nop_op", opcode_EX, 32'h0);
        check("fl_nop_rt", rt_EX, 32'h0);
        check("fl_pend_clr", dut.flush_pend, 32'h0);

        // flush beats bubble
        drv(LW, 5'd1, 5'd12, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drv(RTYPE, 5'd12, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        check("fb_stall", stall_ID, 32'h0);
        tick();
        flush = 1'b0;
        check("fb_op", opcode_EX, 32'h0);
        check("fb_state", dut.state, 32'h0);
        check("fb_bcnt", bubble_cnt, 32'd2);

        // async reset mid-bubble
        drv(LW, 5'd1, 5'd13, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drv(RTYPE, 5'd13, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
        tick();
        check("rb_state", dut.state, 32'h1);
        #2;
        mem_wait = 1'b1;
        RST = 1'b1;
        #1;
        check("rb_state0", dut.state, 32'h0);
        check("rb_bcnt", bubble_cnt, 32'h0);
        check("rb_fcnt", freeze_cnt, 32'h0);
        check("rb_stall", stall_ID, 32'h0);
        check("rb_rt", rt_EX, 32'h0);
        tick();
        RST = 1'b0;
        mem_wait = 1'b0;

        // bubble counter saturation
        for (int i = 0; i < 20; i++) begin
            drv(LW, 5'd1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
            tick();
            drv(RTYPE, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("sat_bcnt", bubble_cnt, 32'd15);
        check("sat_fcnt", freeze_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS datapath, with an integrated load-use hazard detector.
- Captures decoded fields from ID each cycle. Drives EX and the forwarding unit with rs_EX, rt_EX, reg_dest_EX, opcode_EX and WEN_EX.
- Inserts one bubble on a load-use dependency, freezes while the memory stage waits on dhit, and clears on branch/jump flush.

Parameters:
- CNT_W, 16, width of the saturating bubble and freeze event counters.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- mem_wait  in  1  MEM stage holds a load/store without dhit; freeze this register
- flush  in  1  branch/jump resolved taken; squash the ID instruction
- opcode_ID  in  6  decoded opcode (opcode_t)
- rs_ID, rt_ID, rd_ID  in  5 each  register specifiers
- reg_dest_ID  in  2  destination select (SEL_RD/SEL_RT/SEL_R31)
- aluop_ID  in  4  ALU operation (aluop_t)
- WEN_ID, memren_ID, memwen_ID  in  1 each  register write and memory read/write enables
- imm_ID  in  16  immediate field
- rdat1_ID, rdat2_ID, pc4_ID  in  32 each  register file read data and PC+4
- opcode_EX, rs_EX, rt_EX, rd_EX, reg_dest_EX, aluop_EX, WEN_EX, memren_EX, memwen_EX, imm_EX, rdat1_EX, rdat2_EX, pc4_EX  out  same widths  registered copies of the ID fields
- stall_ID  out  1  combinational; hold PC and IF/ID this cycle
- bubble_cnt, freeze_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset (async, RST=1):
  - All EX outputs clear to 0; opcode 0 with zero fields is the NOP.
  - State returns to RUN; flush_pend clears; both counters clear.
  - Reset takes effect immediately, including mid-bubble or mid-freeze.
- Hazard term:
  - reads_rt = opcode_ID is RTYPE, BEQ, BNE, SW or SC.
  - lu_haz = memren_EX & WEN_EX & rt_EX!=0 & (rt_EX==rs_ID | (reads_rt & rt_EX==rt_ID)).
- FSM states: RUN and BUBBLE.
- Per-edge action, in priority order:
  1. mem_wait=1: hold every EX register and the state.
     - If flush=1, set flush_pend.
     - Increment freeze_cnt.
  2. flush | flush_pend: load NOP, clear flush_pend, go to RUN. Flush beats a pending bubble.
  3. state RUN and lu_haz: load NOP, go to BUBBLE, increment bubble_cnt.
  4. Otherwise: load the ID fields, go to RUN.
- BUBBLE always returns to RUN on the next non-frozen edge. By then the load sits in MEM and the forwarding unit's WB path covers the dependency, so back-to-back bubbles for the same load cannot occur.
- stall_ID:
  - stall_ID = mem_wait | (state==RUN & lu_haz & ~flush & ~flush_pend).
  - Deasserted during reset.
- Counters saturate at all-ones and never wrap.
- Latency: one cycle from ID inputs to EX outputs when no stall, freeze or flush occurs.

Decomposition:
- Shared package cpu_types_pkg holds opcode_t, aluop_t, the NOP encoding and the regbits_t width.
- Shared package data_path_muxs_pkg holds the reg_dest select constants.
- Natural sub-module: hazard_detect (combinational; produces lu_haz and reads_rt). The pipeline register, FSM and counters stay in id_ex_stage.

Test Plan:
- Load-use via rs:
  - Stimulus: LW $5 is in EX (memren_EX=1, WEN_EX=1, rt_EX=5); ADD with rs_ID=5 is in ID.
  - Required response: stall_ID=1; next edge loads NOP and state goes to BUBBLE; bubble_cnt=1; the following edge loads the ADD.
- rt-only dependency:
  - LW $7 in EX with SW rt_ID=7 in ID: stall_ID=1.
  - Same LW with ADDI rt_ID=7 in ID (rt not read): no stall.
  - rt_EX=0: never stalls.
- Freeze during BUBBLE:
  - Stimulus: mem_wait=1 for 3 cycles while in BUBBLE.
  - Required response: outputs and state held; freeze_cnt=3; stall_ID=1 throughout; after release, one edge loads the ID fields.
- Flush while frozen:
  - Stimulus: flush=1 while mem_wait=1, then flush=0 and mem_wait=0.
  - Required response: the first unfrozen edge loads NOP and flush_pend clears.
- Flush beats bubble:
  - Stimulus: flush=1 and lu_haz=1 in the same cycle.
  - Required response: stall_ID=0; NOP loaded; state stays RUN; bubble_cnt unchanged.
- Reset and saturation:
  - RST pulses mid-BUBBLE: all outputs go to 0 asynchronously and state is RUN.
  - With CNT_W=4, 20 bubbles: bubble_cnt=15.
